// File: rtl/sram_initiator.sv
// Host-side initiator for the byte-lane SRAM: valid/ready byte/half/word accesses
// with aligned, extended read data, plus a word-range fill engine.
//
// state  | meaning
// IDLE   | waiting for a request or fill_start; memory strobes idle
// ACCESS | single memory cycle for an accepted legal request
// RESP   | response held on resp_* until resp_ready
// FILL   | writing the pattern, one word per cycle, base..top inclusive
module sram_initiator #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [ADDRWIDTH+1:0]   req_addr,
    input  logic [DATAWIDTH-1:0]   req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATAWIDTH-1:0]   resp_rdata,
    output logic                   resp_err,
    input  logic                   fill_start,
    input  logic [ADDRWIDTH-1:0]   fill_base,
    input  logic [ADDRWIDTH-1:0]   fill_top,
    input  logic [DATAWIDTH-1:0]   fill_pattern,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic [ADDRWIDTH-1:0]   mem_addr,
    output logic                   mem_cs,
    output logic [3:0]             mem_we,
    output logic [DATAWIDTH-1:0]   mem_wdata,
    input  logic [DATAWIDTH-1:0]   mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_FILL} state_t;

    state_t                 state_q, state_d;
    logic                   write_q, write_d;
    logic [1:0]             size_q, size_d;
    logic                   signed_q, signed_d;
    logic [ADDRWIDTH+1:0]   addr_q, addr_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [ADDRWIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDRWIDTH-1:0]   fill_top_q, fill_top_d;
    logic [DATAWIDTH-1:0]   fill_pat_q, fill_pat_d;
    logic                   fill_done_q, fill_done_d;

    logic                   req_illegal;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [DATAWIDTH-1:0]   rd_ext;
    logic [3:0]             lane_mask;
    logic [DATAWIDTH-1:0]   lane_wdata;

    always_comb begin
        req_illegal = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    end

    always_comb begin
        rd_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    rd_ext = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'd1:    rd_ext = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane_mask  = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask  = 4'hF;
                lane_wdata = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        fill_cnt_d  = fill_cnt_q;
        fill_top_d  = fill_top_q;
        fill_pat_d  = fill_pat_q;
        fill_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    fill_cnt_d = fill_base;
                    fill_top_d = fill_top;
                    fill_pat_d = fill_pattern;
                    if (fill_base > fill_top) fill_done_d = 1'b1;
                    else                      state_d     = S_FILL;
                end else if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_illegal;
                    state_d  = req_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = write_q ? '0 : rd_ext;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: begin
                // compare before increment so top = all-ones ends without wrapping
                if (fill_cnt_q == fill_top_q) begin
                    state_d     = S_IDLE;
                    fill_done_d = 1'b1;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            fill_cnt_q  <= '0;
            fill_top_q  <= '0;
            fill_pat_q  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_top_q  <= fill_top_d;
            fill_pat_q  <= fill_pat_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign req_ready  = rstn && (state_q == S_IDLE) && !fill_start;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign fill_busy  = (state_q == S_FILL);
    assign fill_done  = fill_done_q;

    always_comb begin
        mem_cs    = 1'b0;
        mem_addr  = '0;
        mem_we    = 4'h0;
        mem_wdata = '0;
        if (state_q == S_FILL) begin
            mem_cs    = 1'b1;
            mem_addr  = fill_cnt_q;
            mem_we    = 4'hF;
            mem_wdata = fill_pat_q;
        end else if (state_q == S_ACCESS) begin
            mem_cs   = 1'b1;
            mem_addr = addr_q[ADDRWIDTH+1:2];
            if (write_q) begin
                mem_we    = lane_mask;
                mem_wdata = lane_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_initiator.sv
// Directed bench for sram_initiator: vector table of host accesses against a
// byte-lane SRAM model, plus fill, backpressure and reset sequences.
module tb_sram_initiator;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        fill_start, fill_busy, fill_done;
    logic [15:0] fill_base, fill_top;
    logic [31:0] fill_pattern;
    logic [15:0] mem_addr;
    logic        mem_cs;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_model [0:65535];

    always #5 clk = ~clk;

    sram_initiator #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .fill_start(fill_start), .fill_base(fill_base), .fill_top(fill_top),
        .fill_pattern(fill_pattern), .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_model[mem_addr];

    always @(posedge clk) begin
        if (mem_cs) begin
            for (int l = 0; l < 4; l++)
                if (mem_we[l]) mem_model[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic [15:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input int idx);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        #1;
        chk($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!v.exp_err) begin
            chk($sformatf("v%0d access mem_cs", idx), {31'b0, mem_cs}, 32'd1);
            chk($sformatf("v%0d mem_we", idx), {28'b0, mem_we}, {28'b0, v.exp_we});
            chk($sformatf("v%0d mem_addr", idx), {16'b0, mem_addr}, {16'b0, v.exp_maddr});
            if (v.wr) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_mwdata);
            chk($sformatf("v%0d early resp_valid", idx), {31'b0, resp_valid}, 32'd0);
            @(posedge clk); #1;
        end else begin
            chk($sformatf("v%0d illegal mem_cs", idx), {31'b0, mem_cs}, 32'd0);
        end
        chk($sformatf("v%0d resp_valid", idx), {31'b0, resp_valid}, 32'd1);
        chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d resp_err", idx), {31'b0, resp_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d resp mem_cs", idx), {31'b0, mem_cs}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk($sformatf("v%0d resp drop", idx), {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        vec_t rv;
        //            wr    sz    sg    addr     wdata          we    maddr    mwdata         rdata          err
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 18'h10, 32'hDEADBEEF, 4'hF, 16'h4, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 18'h10, 32'h0,        4'h0, 16'h4, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 18'h13, 32'h00000011, 4'h8, 16'h4, 32'h11111111, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 18'h10, 32'h0,        4'h0, 16'h4, 32'h0,        32'h11ADBEEF, 1'b0};
        vecs[4]  = '{1'b1, 2'd2, 1'b0, 18'h20, 32'h80017FFE, 4'hF, 16'h8, 32'h80017FFE, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 18'h22, 32'h0,        4'h0, 16'h8, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 18'h22, 32'h0,        4'h0, 16'h8, 32'h0,        32'h00008001, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 18'h20, 32'h0,        4'h0, 16'h8, 32'h0,        32'hFFFFFFFE, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 18'h21, 32'h0,        4'h0, 16'h8, 32'h0,        32'h0000007F, 1'b0};
        vecs[9]  = '{1'b0, 2'd2, 1'b1, 18'h20, 32'h0,        4'h0, 16'h8, 32'h0,        32'h80017FFE, 1'b0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 18'h12, 32'h12345678, 4'hC, 16'h4, 32'h56785678, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 18'h10, 32'h0,        4'h0, 16'h4, 32'h0,        32'h5678BEEF, 1'b0};
        vecs[12] = '{1'b0, 2'd0, 1'b1, 18'h11, 32'h0,        4'h0, 16'h4, 32'h0,        32'hFFFFFFBE, 1'b0};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 18'h10, 32'h0,        4'h0, 16'h4, 32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 18'h21, 32'h0,        4'h0, 16'h0, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b0, 2'd3, 1'b0, 18'h00, 32'h0,        4'h0, 16'h0, 32'h0,        32'h0,        1'b1};
        vecs[16] = '{1'b1, 2'd1, 1'b0, 18'h11, 32'hFFFFFFFF, 4'h0, 16'h0, 32'h0,        32'h0,        1'b1};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 18'h10, 32'h0,        4'h0, 16'h4, 32'h0,        32'h5678BEEF, 1'b0};
        vecs[18] = '{1'b0, 2'd0, 1'b0, 18'h12, 32'h0,        4'h0, 16'h4, 32'h0,        32'h00000078, 1'b0};
        vecs[19] = '{1'b1, 2'd0, 1'b0, 18'h3FFFD, 32'h000000C3, 4'h2, 16'hFFFF, 32'hC3C3C3C3, 32'h0,     1'b0};

        for (int i = 0; i < 65536; i++) mem_model[i] = 32'h0;
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        fill_start = 1'b0; fill_base = '0; fill_top = '0; fill_pattern = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset req_ready", {31'b0, req_ready}, 32'd0);
        chk("reset mem_cs", {31'b0, mem_cs}, 32'd0);
        chk("reset fill_busy", {31'b0, fill_busy}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post reset req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 20; i++) do_req(vecs[i], i);

        // backpressure: response held for three cycles
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 18'h20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp resp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp resp_rdata", resp_rdata, 32'h80017FFE);
            chk("bp req_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp release", {31'b0, resp_valid}, 32'd0);

        // fill with a simultaneous write request: fill must win
        @(negedge clk);
        fill_start = 1'b1; fill_base = 16'h10; fill_top = 16'h13; fill_pattern = 32'hA5A5A5A5;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 18'h400; req_wdata = 32'h12345678;
        #1;
        chk("fill prio req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        fill_start = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill%0d mem_cs", i), {31'b0, mem_cs}, 32'd1);
            chk($sformatf("fill%0d mem_addr", i), {16'b0, mem_addr}, 32'h10 + i);
            chk($sformatf("fill%0d mem_we", i), {28'b0, mem_we}, 32'hF);
            chk($sformatf("fill%0d mem_wdata", i), mem_wdata, 32'hA5A5A5A5);
            chk($sformatf("fill%0d busy", i), {31'b0, fill_busy}, 32'd1);
            chk($sformatf("fill%0d req_ready", i), {31'b0, req_ready}, 32'd0);
            chk($sformatf("fill%0d early done", i), {31'b0, fill_done}, 32'd0);
            @(posedge clk); #1;
        end
        chk("fill done pulse", {31'b0, fill_done}, 32'd1);
        chk("fill end mem_cs", {31'b0, mem_cs}, 32'd0);
        chk("fill end busy", {31'b0, fill_busy}, 32'd0);
        @(posedge clk); #1;
        chk("fill done single", {31'b0, fill_done}, 32'd0);

        rv = '{1'b0, 2'd2, 1'b0, 18'h4C, 32'h0, 4'h0, 16'h13, 32'h0, 32'hA5A5A5A5, 1'b0};
        do_req(rv, 100);
        rv = '{1'b0, 2'd2, 1'b0, 18'h400, 32'h0, 4'h0, 16'h100, 32'h0, 32'h0, 1'b0};
        do_req(rv, 101);

        // empty range: base above top
        @(negedge clk);
        fill_start = 1'b1; fill_base = 16'h5; fill_top = 16'h4;
        @(posedge clk); #1;
        fill_start = 1'b0;
        chk("empty fill mem_cs", {31'b0, mem_cs}, 32'd0);
        chk("empty fill done", {31'b0, fill_done}, 32'd1);
        chk("empty fill busy", {31'b0, fill_busy}, 32'd0);
        @(posedge clk); #1;
        chk("empty fill done clr", {31'b0, fill_done}, 32'd0);
        chk("empty fill mem_cs2", {31'b0, mem_cs}, 32'd0);

        // reset in the middle of a long fill
        @(negedge clk);
        fill_start = 1'b1; fill_base = 16'h100; fill_top = 16'h1FF; fill_pattern = 32'h5A5A5A5A;
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midfill busy", {31'b0, fill_busy}, 32'd1);
        chk("midfill addr", {16'b0, mem_addr}, 32'h102);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst mem_cs", {31'b0, mem_cs}, 32'd0);
        chk("rst mem_we", {28'b0, mem_we}, 32'd0);
        chk("rst mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst fill_busy", {31'b0, fill_busy}, 32'd0);
        chk("rst fill_done", {31'b0, fill_done}, 32'd0);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst idle req_ready", {31'b0, req_ready}, 32'd1);
        rv = '{1'b0, 2'd2, 1'b0, 18'h400, 32'h0, 4'h0, 16'h100, 32'h0, 32'h5A5A5A5A, 1'b0};
        do_req(rv, 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
